// File: rtl/icache_direct_pkg.sv
// icache_direct_pkg: shared configuration for the direct-mapped instruction cache.
//   - default geometry (ICACHE_INDEX_W, ICACHE_ADDR_W)
//   - instruction / address bus widths and their typedefs
//   - controller state encoding (IC_IDLE / IC_REQ / IC_WAIT)
//   - word_align(): clears the byte-offset bits of a fetch address
package icache_direct_pkg;

    localparam int ICACHE_INDEX_W = 8;
    localparam int ICACHE_ADDR_W  = 17;
    localparam int INST_BUS_W     = 32;
    localparam int ADDR_BUS_W     = 32;

    typedef logic [INST_BUS_W-1:0] inst_bus_t;
    typedef logic [ADDR_BUS_W-1:0] addr_bus_t;

    typedef enum logic [1:0] {
        IC_IDLE = 2'd0,
        IC_REQ  = 2'd1,
        IC_WAIT = 2'd2
    } ic_state_e;

    function automatic addr_bus_t word_align(input addr_bus_t addr);
        return {addr[ADDR_BUS_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_array.sv
// icache_array: tag/data/valid storage for icache_direct.
//   clk, rst      : clock, synchronous active-high reset (clears valid bits only)
//   rd_index_i    : combinational read index -> rd_valid_o / rd_tag_o / rd_data_o
//   wr_en_i       : synchronous line write at wr_index_i with wr_tag_i / wr_data_i
//   inv_all_i     : clear every valid bit at the next edge; beats a same-cycle write
// A read and write to the same index in one cycle returns the old contents.
module icache_array
    import icache_direct_pkg::*;
#(
    parameter int INDEX_W = ICACHE_INDEX_W,
    parameter int TAG_W   = ICACHE_ADDR_W - 2 - ICACHE_INDEX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output inst_bus_t          rd_data_o,
    input  logic               wr_en_i,
    input  logic [INDEX_W-1:0] wr_index_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  inst_bus_t          wr_data_i,
    input  logic               inv_all_i
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    inst_bus_t        data_q [LINES];

    // Next valid vector: invalidate-all wins, so a coincident fill stays invalid.
    always_comb begin
        valid_d = valid_q;
        if (inv_all_i) begin
            valid_d = '0;
        end else if (wr_en_i) begin
            valid_d[wr_index_i] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid bits are the only reset state.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/data payload; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, one-word-per-line instruction cache between IF
// and the mem_ctrl instruction port.
//   clk, rst, rdy         : clock, sync active-high reset, global ready (low = freeze)
//   req_i, pc_i, flush_i  : IF fetch request, fetch address, abandon request
//   inv_all_i             : invalidate every line
//   inst_o, inst_valid_o  : returned instruction (hit: same cycle; miss: on fill)
//   hit_o                 : combinational tag hit for pc_i
//   mc_enable_o, mc_addr_o: registered fetch request to mem_ctrl
//   mc_inst_i, mc_busy_i, mc_mem_busy_i, mc_finished_i : mem_ctrl response side
// Optional feature, macro ICACHE_STAT_EN: adds hit_cnt_o / miss_cnt_o counters
// of accepted IDLE-state hits and misses.
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int INDEX_W = ICACHE_INDEX_W,
    parameter int ADDR_W  = ICACHE_ADDR_W
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    input  logic      req_i,
    input  addr_bus_t pc_i,
    input  logic      flush_i,
    input  logic      inv_all_i,
    output inst_bus_t inst_o,
    output logic      inst_valid_o,
    output logic      hit_o,
    output logic      mc_enable_o,
    output addr_bus_t mc_addr_o,
    input  inst_bus_t mc_inst_i,
    input  logic      mc_busy_i,
    input  logic      mc_mem_busy_i,
`ifdef ICACHE_STAT_EN
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o,
`endif
    input  logic      mc_finished_i
);

    localparam int TAG_W = ADDR_W - 2 - INDEX_W;

    logic [TAG_W-1:0] rd_tag_s;
    logic             rd_valid_s;
    inst_bus_t        rd_data_s;
    logic             hit_s;
    logic             fill_we_s;
    logic             pc_match_s;
    logic             hit_acc_s;
    logic             miss_acc_s;
    logic             inst_valid_s;
    inst_bus_t        inst_s;
    logic [1:0]       unused_pc_lsb_s;

    ic_state_e state_q,         state_d;
    addr_bus_t miss_pc_q,       miss_pc_d;
    logic      mc_enable_q,     mc_enable_d;
    addr_bus_t mc_addr_q,       mc_addr_d;
    logic      flush_pending_q, flush_pending_d;

    assign unused_pc_lsb_s = pc_i[1:0];

    // Array writes and invalidates are frozen together with the rest of the state.
    icache_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_index_i (pc_i[INDEX_W+1:2]),
        .rd_valid_o (rd_valid_s),
        .rd_tag_o   (rd_tag_s),
        .rd_data_o  (rd_data_s),
        .wr_en_i    (fill_we_s && rdy),
        .wr_index_i (miss_pc_q[INDEX_W+1:2]),
        .wr_tag_i   (miss_pc_q[ADDR_W-1:INDEX_W+2]),
        .wr_data_i  (mc_inst_i),
        .inv_all_i  (inv_all_i && rdy)
    );

    assign hit_s      = rd_valid_s && (rd_tag_s == pc_i[ADDR_W-1:INDEX_W+2]);
    assign pc_match_s = (word_align(pc_i) == miss_pc_q);

    // Controller next-state, fill strobe and same-cycle return data.
    always_comb begin
        state_d         = state_q;
        miss_pc_d       = miss_pc_q;
        mc_enable_d     = mc_enable_q;
        mc_addr_d       = mc_addr_q;
        flush_pending_d = flush_pending_q;
        fill_we_s       = 1'b0;
        hit_acc_s       = 1'b0;
        miss_acc_s      = 1'b0;
        inst_valid_s    = 1'b0;
        inst_s          = 32'd0;
        case (state_q)
            IC_IDLE: begin
                if (req_i && !flush_i) begin
                    if (hit_s) begin
                        inst_s       = rd_data_s;
                        inst_valid_s = 1'b1;
                        hit_acc_s    = 1'b1;
                    end else begin
                        miss_pc_d  = word_align(pc_i);
                        miss_acc_s = 1'b1;
                        state_d    = IC_REQ;
                    end
                end else begin
                    state_d = IC_IDLE;
                end
            end
            IC_REQ: begin
                // Nothing has been issued yet, so a flush simply drops the miss.
                if (flush_i) begin
                    state_d = IC_IDLE;
                end else if (!mc_busy_i && !mc_mem_busy_i) begin
                    mc_enable_d = 1'b1;
                    mc_addr_d   = miss_pc_q;
                    state_d     = IC_WAIT;
                end else begin
                    state_d = IC_REQ;
                end
            end
            IC_WAIT: begin
                // mem_ctrl cannot abort: the fill always lands, but a flushed
                // fetch is never handed back to IF.
                if (mc_finished_i) begin
                    fill_we_s       = 1'b1;
                    mc_enable_d     = 1'b0;
                    flush_pending_d = 1'b0;
                    state_d         = IC_IDLE;
                    if (!flush_pending_q && !flush_i && pc_match_s && rdy) begin
                        inst_s       = mc_inst_i;
                        inst_valid_s = 1'b1;
                    end else begin
                        inst_valid_s = 1'b0;
                    end
                end else if (flush_i) begin
                    flush_pending_d = 1'b1;
                end else begin
                    state_d = IC_WAIT;
                end
            end
            default: begin
                state_d     = IC_IDLE;
                mc_enable_d = 1'b0;
            end
        endcase
    end

    // Controller registers; rdy low holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IC_IDLE;
            miss_pc_q       <= 32'd0;
            mc_enable_q     <= 1'b0;
            mc_addr_q       <= 32'd0;
            flush_pending_q <= 1'b0;
        end else if (rdy) begin
            state_q         <= state_d;
            miss_pc_q       <= miss_pc_d;
            mc_enable_q     <= mc_enable_d;
            mc_addr_q       <= mc_addr_d;
            flush_pending_q <= flush_pending_d;
        end
    end

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt_q,  hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Accepted-lookup counters; wrap naturally at 2^32.
    always_comb begin
        hit_cnt_d  = hit_acc_s  ? hit_cnt_q  + 32'd1 : hit_cnt_q;
        miss_cnt_d = miss_acc_s ? miss_cnt_q + 32'd1 : miss_cnt_q;
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else if (rdy) begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    logic unused_acc_s;
    assign unused_acc_s = hit_acc_s ^ miss_acc_s;
`endif

    // Return path is combinational for zero-latency hits; forced quiet in reset.
    assign hit_o        = hit_s;
    assign inst_valid_o = inst_valid_s && !rst;
    assign inst_o       = rst ? 32'd0 : inst_s;
    assign mc_enable_o  = mc_enable_q;
    assign mc_addr_o    = mc_addr_q;

endmodule
